// File: rtl/fir_mac_engine.sv
// Multi-channel FIR multiply-accumulate engine: one shared coefficient stream, NCH sample lanes.
// Define FIR_SAT_EN to saturate each channel result; otherwise the scaled result wraps.
module fir_mac_engine #(
   parameter  int DATA_W = 16,
   parameter  int COEF_W = 16,
   parameter  int NTAPS  = 1021,
   parameter  int NCH    = 2,
   localparam int AW     = $clog2(NTAPS),
   localparam int ACC_W  = DATA_W + COEF_W + AW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic [AW-1:0]         coef_addr,
   input  logic [COEF_W-1:0]     coef_data,
   output logic                  seq_req,
   input  logic [NCH*DATA_W-1:0] smpl_in,
   output logic                  busy,
   output logic                  out_valid,
   output logic [NCH*DATA_W-1:0] smpl_out
);

   localparam int PW = DATA_W + COEF_W;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state, state_nxt;
   logic   mac_en;
   logic   last_addr;
   logic   run_start;

   logic signed [PW-1:0]    prod    [NCH];
   logic signed [ACC_W-1:0] acc     [NCH];
   logic signed [ACC_W-1:0] acc_nxt [NCH];
   logic        [DATA_W-1:0] res    [NCH];

   assign last_addr = (coef_addr == AW'(NTAPS - 1));
   assign run_start = (state == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      seq_req   = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            seq_req = 1'b1;
            if (abort)          state_nxt = IDLE;
            else if (last_addr) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = abort ? IDLE : DONE;
         DONE: begin
            out_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address saturates at NTAPS-1 and holds outside RUN; aborted runs leave it where it stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_addr <= '0;
         mac_en    <= 1'b0;
      end else begin
         mac_en <= seq_req && !abort;
         if (run_start)
            coef_addr <= '0;
         else if (state == RUN && !abort && !last_addr)
            coef_addr <= coef_addr + AW'(1);
      end
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         prod[c]    = PW'($signed(coef_data)) * PW'($signed(smpl_in[c*DATA_W +: DATA_W]));
         acc_nxt[c] = acc[c] + ACC_W'(prod[c]);
         res[c]     = acc_nxt[c][PW-2 : COEF_W-1];
`ifdef FIR_SAT_EN
         // In range only when every bit above the result slice matches its sign bit.
         if (acc_nxt[c][ACC_W-1 : PW-2] != {(AW+2){acc_nxt[c][ACC_W-1]}})
            res[c] = acc_nxt[c][ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
      end
   end

   // NOTE: the accumulators are a handful of registers, not a RAM, so they take the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) acc[c] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (run_start)   acc[c] <= '0;
            else if (mac_en) acc[c] <= acc_nxt[c];
         end
      end
   end

   // The last product lands during DRAIN, so results load from acc_nxt and are visible in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smpl_out <= '0;
      end else if (state == DRAIN && !abort) begin
         for (int c = 0; c < NCH; c++) smpl_out[c*DATA_W +: DATA_W] <= res[c];
      end
   end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine (NTAPS=4, NCH=2) against a plain-arithmetic dot-product model.
module tb_fir_mac_engine;

   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int NTAPS  = 4;
   localparam int NCH    = 2;
   localparam int AW     = $clog2(NTAPS);

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  start;
   logic                  abort;
   logic [AW-1:0]         coef_addr;
   logic [COEF_W-1:0]     coef_data;
   logic                  seq_req;
   logic [NCH*DATA_W-1:0] smpl_in;
   logic                  busy;
   logic                  out_valid;
   logic [NCH*DATA_W-1:0] smpl_out;

   logic                  q_clr;
   int                    sidx;
   logic [COEF_W-1:0]     coef_mem [NTAPS];
   logic [NCH*DATA_W-1:0] smpl_mem [NTAPS];
   logic [DATA_W-1:0]     last_exp [NCH];

   int passed = 0;
   int total  = 0;

   fir_mac_engine #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .NCH(NCH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .coef_addr(coef_addr), .coef_data(coef_data), .seq_req(seq_req),
      .smpl_in(smpl_in), .busy(busy), .out_valid(out_valid), .smpl_out(smpl_out)
   );

   always #5 clk = ~clk;

   // Coefficient ROM and sample queue, each with one cycle of read latency.
   always @(posedge clk) begin
      coef_data <= coef_mem[coef_addr];
      if (q_clr) sidx <= 0;
      else if (seq_req) begin
         smpl_in <= (sidx < NTAPS) ? smpl_mem[sidx] : '0;
         sidx    <= sidx + 1;
      end
   end

   // Expected result: dot product of coefficients and samples, scaled by 2^-(COEF_W-1).
   function automatic logic [DATA_W-1:0] model(int c);
      longint sum = 0;
      longint s;
      longint hi = (longint'(1) <<< (DATA_W - 1)) - 1;
      longint lo = -(longint'(1) <<< (DATA_W - 1));
      logic [DATA_W-1:0] smp;
      for (int k = 0; k < NTAPS; k++) begin
         smp = smpl_mem[k][c*DATA_W +: DATA_W];
         sum += longint'($signed(coef_mem[k])) * longint'($signed(smp));
      end
      s = sum >>> (COEF_W - 1);
`ifdef FIR_SAT_EN
      if (s > hi) s = hi;
      if (s < lo) s = lo;
`else
      if (s > hi || s < lo) s = s;
`endif
      return s[DATA_W-1:0];
   endfunction

   task automatic set_const(logic [COEF_W-1:0] cf, logic [DATA_W-1:0] sm);
      for (int k = 0; k < NTAPS; k++) begin
         coef_mem[k] = cf;
         smpl_mem[k] = {NCH{sm}};
      end
   endtask

   task automatic set_random();
      logic [15:0] pick;
      for (int k = 0; k < NTAPS; k++) begin
         pick = 16'($urandom_range(0, 7));
         coef_mem[k] = (pick == 0) ? 16'h8000 : (pick == 1) ? 16'h7FFF : 16'($urandom);
         for (int c = 0; c < NCH; c++)
            smpl_mem[k][c*DATA_W +: DATA_W] = (pick == 2) ? 16'h8000 : 16'($urandom);
      end
   endtask

   // Runs from the cycle start is driven; returns on the negedge where out_valid is seen.
   task automatic run_body(string name, int extra);
      int  lat = -1;
      int  nseq = 0;
      bit  addr_ok = 1'b1;
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         @(negedge clk);
         start = (i == extra);
         if (seq_req) begin
            if (coef_addr !== AW'(nseq)) addr_ok = 1'b0;
            nseq++;
         end
         if (out_valid) lat = i;
      end
      start = 1'b0;
      total++;
      if (lat !== NTAPS + 2) $display("FAIL %s latency: got %0d expected %0d", name, lat, NTAPS + 2);
      else passed++;
      total++;
      if (nseq !== NTAPS) $display("FAIL %s seq_req cycles: got %0d expected %0d", name, nseq, NTAPS);
      else passed++;
      total++;
      if (!addr_ok) $display("FAIL %s coef_addr order: got out-of-order expected 0..%0d", name, NTAPS - 1);
      else passed++;
      for (int c = 0; c < NCH; c++) begin
         last_exp[c] = model(c);
         total++;
         if (smpl_out[c*DATA_W +: DATA_W] !== last_exp[c])
            $display("FAIL %s ch%0d: got %h expected %h", name, c, smpl_out[c*DATA_W +: DATA_W], last_exp[c]);
         else passed++;
      end
   endtask

   task automatic do_run(string name, int extra);
      @(negedge clk);
      q_clr = 1'b1;
      @(negedge clk);
      q_clr = 1'b0;
      start = 1'b1;
      run_body(name, extra);
   endtask

   task automatic check_idle_outputs(string name);
      total++;
      if ({busy, seq_req, out_valid} !== 3'b000 || coef_addr !== '0 || smpl_out !== '0)
         $display("FAIL %s: got busy=%b seq_req=%b out_valid=%b addr=%0d out=%h expected all zero",
                  name, busy, seq_req, out_valid, coef_addr, smpl_out);
      else passed++;
   endtask

   task automatic watch_no_valid(string name, int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      total++;
      if (seen !== 0) $display("FAIL %s stray out_valid: got %0d expected 0", name, seen);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; q_clr = 1'b1;
      set_const('0, '0);
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      q_clr = 1'b0;
      watch_no_valid("reset_release", 4);
   endtask

   task automatic test_basic();
      set_const(16'h4000, 16'h1000);
      do_run("basic", 0);
   endtask

   task automatic test_saturate();
      set_const(16'h7FFF, 16'h7FFF);
      do_run("full_scale", 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         set_random();
         do_run($sformatf("random%0d", r), 0);
      end
   endtask

   task automatic test_double_start();
      set_random();
      do_run("double_start", 2);
      watch_no_valid("double_start_tail", 8);
   endtask

   task automatic test_back_to_back();
      set_random();
      do_run("b2b_first", 0);
      start = 1'b1;       // held through DONE, where it must be ignored
      q_clr = 1'b1;
      set_random();
      @(negedge clk);
      q_clr = 1'b0;
      total++;
      if (busy !== 1'b0) $display("FAIL b2b_idle busy: got %b expected 0", busy);
      else passed++;
      run_body("b2b_second", 0);
   endtask

   task automatic test_abort();
      logic [DATA_W-1:0] prior [NCH];
      set_random();
      do_run("pre_abort", 0);
      prior = last_exp;
      set_const(16'h4000, 16'h1000);
      @(negedge clk); q_clr = 1'b1;
      @(negedge clk); q_clr = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      total++;
      if (busy !== 1'b0 || seq_req !== 1'b0)
         $display("FAIL abort_run idle: got busy=%b seq_req=%b expected 0 0", busy, seq_req);
      else passed++;
      watch_no_valid("abort_run", 6);
      for (int c = 0; c < NCH; c++) begin
         total++;
         if (smpl_out[c*DATA_W +: DATA_W] !== prior[c])
            $display("FAIL abort_run hold ch%0d: got %h expected %h", c, smpl_out[c*DATA_W +: DATA_W], prior[c]);
         else passed++;
      end
      do_run("after_abort", 0);
      // Abort during DRAIN also drops the result.
      set_random();
      prior = last_exp;
      @(negedge clk); q_clr = 1'b1;
      @(negedge clk); q_clr = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (NTAPS) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL abort_drain: got busy=%b out_valid=%b expected 0 0", busy, out_valid);
      else passed++;
      watch_no_valid("abort_drain", 6);
      total++;
      if (smpl_out !== {prior[1], prior[0]})
         $display("FAIL abort_drain hold: got %h expected %h", smpl_out, {prior[1], prior[0]});
      else passed++;
   endtask

   task automatic test_reset_mid_run();
      set_random();
      @(negedge clk); q_clr = 1'b1;
      @(negedge clk); q_clr = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid_run");
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_valid("reset_mid_run_release", 10);
      set_const(16'h4000, 16'h1000);
      do_run("after_reset", 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_random();
      test_double_start();
      test_back_to_back();
      test_abort();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
